// File: rtl/piso_shift_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : piso_shift_serializer
//  Function : parallel-in / serial-out transmitter with per-bit valid and
//             frame markers; frames may be loaded back-to-back with zero gap.
//  Revision : 1.0
// ============================================================================
module piso_shift_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_last
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_ZERO     = '0;
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

  localparam logic [0:0] c_S_IDLE  = 1'b0;
  localparam logic [0:0] c_S_SHIFT = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_shift;
  logic             w_cnt_zero;
  logic             w_ready_state;
  logic             w_accept;
  logic             w_bit;
  logic [WIDTH-1:0] w_shifted;

  assign w_in_shift    = (r_state == c_S_SHIFT);
  assign w_cnt_zero    = (r_cnt == c_ZERO);
  assign w_ready_state = (r_state == c_S_IDLE) || (w_in_shift && w_cnt_zero);
  assign w_accept      = load_valid && w_ready_state && !reset;

  // The output end of the register is fixed by bit order; zero fill behind it.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_bit     = r_shift[WIDTH-1];
      assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_bit     = r_shift[0];
      assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_S_IDLE;
      r_shift <= '0;
      r_cnt   <= c_ZERO;
    end else if (w_accept) begin
      r_state <= c_S_SHIFT;
      r_shift <= parallel_in;
      r_cnt   <= c_LAST_IDX;
    end else if (w_in_shift) begin
      if (!w_cnt_zero) begin
        r_shift <= w_shifted;
        r_cnt   <= r_cnt - c_ONE;
      end else begin
        // Clearing here keeps serial_out at 0 for the whole idle period.
        r_state <= c_S_IDLE;
        r_shift <= '0;
      end
    end
  end

  assign load_ready   = w_ready_state && !reset;
  assign serial_valid = w_in_shift;
  assign serial_out   = w_bit && w_in_shift;
  assign frame_start  = w_in_shift && (r_cnt == c_LAST_IDX);
  assign frame_last   = w_in_shift && w_cnt_zero;

endmodule
`default_nettype wire

// File: tb/tb_piso_shift_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piso_shift_serializer
//  Function : bench for piso_shift_serializer (MSB-first and LSB-first copies)
//  Revision : 1.0
// ============================================================================
module tb_piso_shift_serializer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] parallel_in;
  logic             load_valid;

  logic m_ready, m_out, m_valid, m_fs, m_fl;
  logic l_ready, l_out, l_valid, l_fs, l_fl;

  logic [3:0] r_chain;

  int n_vec = 0;
  int n_err = 0;

  bit qm[$];
  bit ql[$];

  always #5 clk = ~clk;

  piso_shift_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .parallel_in(parallel_in), .load_valid(load_valid),
    .load_ready(m_ready), .serial_out(m_out), .serial_valid(m_valid),
    .frame_start(m_fs), .frame_last(m_fl)
  );

  piso_shift_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .parallel_in(parallel_in), .load_valid(load_valid),
    .load_ready(l_ready), .serial_out(l_out), .serial_valid(l_valid),
    .frame_start(l_fs), .frame_last(l_fl)
  );

  // Downstream 4-stage D flip-flop chain fed by the MSB-first stream.
  always_ff @(posedge clk) r_chain <= {r_chain[2:0], m_out};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference: each DUT is a queue of bits still to be sent in the current frame.
  task automatic check_one(input string tag, ref bit q[$], input logic rdy,
                           input logic so, input logic sv, input logic fs, input logic fl);
    bit e_valid;
    e_valid = (q.size() != 0);
    chk({tag, "_valid"}, {31'd0, sv}, {31'd0, e_valid});
    chk({tag, "_out"},   {31'd0, so}, {31'd0, e_valid ? q[0] : 1'b0});
    chk({tag, "_start"}, {31'd0, fs}, {31'd0, q.size() == WIDTH});
    chk({tag, "_last"},  {31'd0, fl}, {31'd0, q.size() == 1});
    chk({tag, "_ready"}, {31'd0, rdy}, {31'd0, !reset && (q.size() <= 1)});
  endtask

  task automatic step(input logic rst, input logic lv, input logic [WIDTH-1:0] d);
    bit take;
    @(negedge clk);
    reset       = rst;
    load_valid  = lv;
    parallel_in = d;
    #1;
    check_one("msb", qm, m_ready, m_out, m_valid, m_fs, m_fl);
    check_one("lsb", ql, l_ready, l_out, l_valid, l_fs, l_fl);
    take = !rst && lv && (qm.size() <= 1);
    @(posedge clk);
    if (rst) begin
      qm.delete();
      ql.delete();
    end else if (take) begin
      qm.delete();
      ql.delete();
      for (int k = 0; k < WIDTH; k++) begin
        qm.push_back(d[WIDTH-1-k]);
        ql.push_back(d[k]);
      end
    end else if (qm.size() != 0) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
    end
  endtask

  initial begin
    reset       = 1'b1;
    load_valid  = 1'b0;
    parallel_in = '0;

    // Reset for two edges, with a load pulse during reset that must be ignored.
    step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'hF);

    // Single frame then idle.
    step(1'b0, 1'b1, 4'b1011);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'h0);

    // Back-to-back frames with load_valid held.
    step(1'b0, 1'b1, 4'b1011);
    step(1'b0, 1'b1, 4'b1011);
    step(1'b0, 1'b1, 4'b1011);
    step(1'b0, 1'b1, 4'b1011);
    step(1'b0, 1'b1, 4'b0110);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'h0);

    // LSB-first style word.
    step(1'b0, 1'b1, 4'b0001);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'h0);

    // Mid-frame reset aborts, then a clean frame.
    step(1'b0, 1'b1, 4'b1111);
    step(1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'b1010);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'h0);

    // Early load_valid during bit 2 is held until the last-bit edge.
    step(1'b0, 1'b1, 4'b1100);
    step(1'b0, 1'b0, 4'b0101);
    step(1'b0, 1'b1, 4'b0011);
    step(1'b0, 1'b1, 4'b0011);
    step(1'b0, 1'b1, 4'b0011);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'h0);

    // Loopback into the downstream flip-flop chain.
    step(1'b0, 1'b1, 4'b1001);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0);
    #1;
    chk("loop_chain", {28'd0, r_chain}, 32'h9);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 4'h0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
           WIDTH'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso_shift_serializer.md
Name: piso_shift_serializer

Overview:
Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, with per-bit valid and frame markers. Produces the serial bit stream consumed by the team's D-flip-flop shift-register chains and serial receivers. Words can be loaded back-to-back with no idle cycle between frames.

Parameters:
WIDTH, 4, word width in bits (>= 2).
MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 transmitted first.

Ports:
clk  input  1  rising-edge clock; all state changes on posedge clk.
reset  input  1  synchronous, active-high reset; sampled only on posedge clk.
parallel_in  input  WIDTH  word to transmit; sampled on an accepting edge.
load_valid  input  1  parallel_in holds a word to send.
load_ready  output  1  serializer can accept a word at the next edge.
serial_out  output  1  current serial bit; 0 when serial_valid = 0.
serial_valid  output  1  serial_out carries a frame bit this cycle.
frame_start  output  1  high during the first bit of each frame.
frame_last  output  1  high during the last bit of each frame.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: on any posedge clk with reset = 1: state <= IDLE, shift register <= 0, bit counter <= 0. After that edge: serial_out = 0, serial_valid = 0, frame_start = 0, frame_last = 0, load_ready = 1.
- While reset = 1, load_ready is forced to 0. A load_valid pulse during reset is ignored.
- Reset mid-frame aborts the frame immediately. No partial bits are emitted after the reset edge.
- States:
  - IDLE: load_ready = 1; serial_valid = 0.
  - SHIFT: a frame bit is on serial_out; serial_valid = 1.
- Accept: a word is accepted on a posedge where load_valid && load_ready && !reset. On acceptance:
  - shift register <= parallel_in;
  - counter <= WIDTH-1;
  - state <= SHIFT.
- Latency: the first bit appears in the cycle after the accepting edge, i.e. 1 clock from accept to first bit.
- serial_out is driven directly from a register (no combinational path from inputs):
  - MSB_FIRST = 1: the top bit of the shift register;
  - MSB_FIRST = 0: the bottom bit of the shift register.
- Each posedge in SHIFT with counter != 0: shift one position toward the output end (zero fill) and decrement the counter.
- Frame markers:
  - frame_start = 1 in SHIFT when counter == WIDTH-1.
  - frame_last = 1 in SHIFT when counter == 0.
  - Both are registered-state decodes and never glitch on inputs.
- load_ready = (state == IDLE) || (state == SHIFT && counter == 0). It depends only on state, never on load_valid.
- Last-bit edge (SHIFT, counter == 0):
  - if load_valid = 1: reload per Accept and stay in SHIFT. Frames are contiguous, with zero gap.
  - otherwise: state <= IDLE and serial_out returns to 0.
- load_valid asserted in SHIFT with counter != 0: ignored, and parallel_in is not sampled. The upstream must hold load_valid until load_ready.
- Changes on parallel_in after acceptance have no effect on the frame in flight.
- Each frame is exactly WIDTH serial_valid cycles: no bit is dropped or duplicated.
- The counter is ceil(log2(WIDTH)) bits wide and never wraps. It reloads only on accept.

Test Plan:
1. WIDTH=4, MSB_FIRST=1, reset high for 2 edges then low; load 4'b1011 with one load_valid pulse -> next 4 cycles: serial_out 1,0,1,1; serial_valid=1 throughout; frame_start in cycle 1 only; frame_last in cycle 4 only; load_ready=0 in cycles 1-3; then IDLE with serial_out=0.
2. Back-to-back: 4'b1011 then 4'b0110, with load_valid held high and the second word presented when load_ready rises in the last-bit cycle -> 8 contiguous valid bits 1,0,1,1,0,1,1,0; frame_start in cycles 1 and 5; frame_last in cycles 4 and 8.
3. MSB_FIRST=0, load 4'b0001 -> serial_out 1,0,0,0.
4. Load 4'b1111, assert reset for one edge after bit 2 -> cycle after that edge: serial_valid=0, serial_out=0, frame_last never asserted. Then load 4'b1010 -> 1,0,1,0 emitted cleanly.
5. Load 4'b1100; raise load_valid with 4'b0011 during bit 2 and hold it -> ready stays 0 until bit 4. The second word is accepted at the bit-4 edge and emits 0,0,1,1 with no gap. Changing parallel_in during bit 2 does not alter the first frame.
6. Loopback: serial_out feeding the team's 4-stage D-flip-flop shift chain, word 4'b1001 -> after 4 shift clocks the chain holds 1,0,0,1.
